// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c transaction arbiter.
// - master_state_t : state encodings reported by the i2c master
// - READ / WRITE   : master_rw direction encodings
// - arb_state_t    : arbiter sequencing FSM states
package i2c_pkg;

    typedef enum logic [2:0] {
        M_IDLE       = 3'd0,
        M_ADDRESSING = 3'd1,
        M_WAITING    = 3'd2,
        M_READING    = 3'd3,
        M_WRITING    = 3'd4,
        M_DONE       = 3'd5
    } master_state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LAUNCH,
        ARB_RUN,
        ARB_HOLD
    } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker.
// Searches req upward from ptr, wrapping at NUM_REQ, and reports the first
// set bit.
// Ports:
//   req   : request vector
//   ptr   : index where the search starts
//   grant : one-hot winner (all zero when no request)
//   idx   : winner index
//   any   : at least one request present
module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               any
);

    logic [PW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PW'((32'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin transaction controller sharing one i2c master between
// NUM_REQ requesters. Each grant runs exactly one byte transaction:
// master_rst is held for LAUNCH_CYCLES, the master runs until it reports
// DONE, the stop condition is given DONE_HOLD cycles, then the requester
// gets a one-cycle req_done (with rdata captured for reads).
// Optional feature: define I2C_ARB_TIMEOUT_EN to add a RUN-phase watchdog of
// TIMEOUT_CYCLES that completes the transaction with req_error.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_rw/req_wdata : per-requester request, direction, write byte
//   req_grant/req_done/req_error : per-requester grant, completion, timeout
//   rdata : last read byte;  busy : FSM not idle
//   master_rst/master_rw/master_data_in : drive the master
//   master_state/master_data_out        : from the master
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LAUNCH_CYCLES  = 2,
    parameter int DONE_HOLD      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_grant,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [NUM_REQ-1:0]   req_error,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic                 master_rst,
    output logic                 master_rw,
    output logic [7:0]           master_data_in,
    input  logic [2:0]           master_state,
    input  logic [7:0]           master_data_out
);

    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CMAX = (TIMEOUT_CYCLES > LAUNCH_CYCLES)
                        ? ((TIMEOUT_CYCLES > DONE_HOLD) ? TIMEOUT_CYCLES : DONE_HOLD)
                        : ((LAUNCH_CYCLES > DONE_HOLD) ? LAUNCH_CYCLES : DONE_HOLD);
    localparam int CW   = $clog2(CMAX + 1);

    arb_state_t           state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        winner;
    logic [CW-1:0]        cnt;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;
    logic [7:0]           pick_wdata;
    logic [PW-1:0]        ptr_next;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        pick_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PW'(i) == pick_idx) begin
                pick_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    assign ptr_next = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
    assign busy     = (state != ARB_IDLE);

`ifdef I2C_ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0] err_q;
    assign req_error = err_q;
`else
    assign req_error = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ARB_IDLE;
            ptr            <= '0;
            winner         <= '0;
            cnt            <= '0;
            req_grant      <= '0;
            req_done       <= '0;
            rdata          <= 8'h00;
            master_rst     <= 1'b1;
            master_rw      <= WRITE;
            master_data_in <= 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q          <= '0;
`endif
        end else begin
            req_done <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q    <= '0;
`endif
            case (state)
                ARB_IDLE: begin
                    master_rst <= 1'b1;
                    if (pick_any) begin
                        req_grant      <= pick_grant;
                        winner         <= pick_idx;
                        master_rw      <= req_rw[pick_idx];
                        master_data_in <= pick_wdata;
                        cnt            <= '0;
                        state          <= ARB_LAUNCH;
                    end
                end
                ARB_LAUNCH: begin
                    if (cnt == CW'(LAUNCH_CYCLES - 1)) begin
                        master_rst <= 1'b0;
                        cnt        <= '0;
                        state      <= ARB_RUN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ARB_RUN: begin
                    if (master_state == M_DONE) begin
                        if (master_rw == READ) begin
                            rdata <= master_data_out;
                        end
                        cnt   <= '0;
                        state <= ARB_HOLD;
`ifdef I2C_ARB_TIMEOUT_EN
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 2)) begin
                        // Registered pulse lands in the TIMEOUT_CYCLES-th RUN
                        // cycle; master_rst rises from IDLE one cycle later.
                        req_done  <= req_grant;
                        err_q     <= req_grant;
                        req_grant <= '0;
                        ptr       <= ptr_next;
                        state     <= ARB_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
`endif
                    end
                end
                ARB_HOLD: begin
                    if (cnt == CW'(DONE_HOLD - 1)) begin
                        req_done   <= req_grant;
                        req_grant  <= '0;
                        master_rst <= 1'b1;
                        ptr        <= ptr_next;
                        state      <= ARB_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
module tb_i2c_txn_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_rw    = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   req_grant;
    logic [N-1:0]   req_done;
    logic [N-1:0]   req_error;
    logic [7:0]     rdata;
    logic           busy;
    logic           master_rst;
    logic           master_rw;
    logic [7:0]     master_data_in;
    logic [2:0]     master_state    = 3'd0;
    logic [7:0]     master_data_out = 8'h00;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         idx;
        logic       err;
        logic [7:0] rdata;
        logic       rw;
        logic [7:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    i2c_txn_arbiter #(
        .NUM_REQ        (N),
        .LAUNCH_CYCLES  (2),
        .DONE_HOLD      (2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_rw          (req_rw),
        .req_wdata       (req_wdata),
        .req_grant       (req_grant),
        .req_done        (req_done),
        .req_error       (req_error),
        .rdata           (rdata),
        .busy            (busy),
        .master_rst      (master_rst),
        .master_rw       (master_rw),
        .master_data_in  (master_data_in),
        .master_state    (master_state),
        .master_data_out (master_data_out)
    );

    // Master model: ADDRESSING, two unknown encodings (6, 7), data phase,
    // then DONE held until master_rst. Read data is ~data_in.
    logic stuck = 1'b0;
    int   mc    = 0;
    always @(posedge clk) begin
        if (master_rst) begin
            master_state <= 3'd0;
            mc           <= 0;
        end else if (stuck) begin
            master_state <= 3'd2;
        end else begin
            mc              <= mc + 1;
            master_data_out <= ~master_data_in;
            case (mc)
                0:       master_state <= 3'd1;
                1:       master_state <= 3'd6;
                2:       master_state <= 3'd7;
                3:       master_state <= master_rw ? 3'd3 : 3'd4;
                default: master_state <= 3'd5;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    logic [N-1:0] prev_grant = '0;
    int           streak     = 0;
    exp_t         mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            prev_grant = '0;
            streak     = 0;
        end else begin
            if (req_grant != '0 && prev_grant == '0) begin
                if (exp_q.size() == 0) check("grant_unexpected", 32'(req_grant), 0);
                else                   check("grant_order", 32'(req_grant), 32'(1 << exp_q[0].idx));
            end
            if (req_done != '0) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(req_done), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_onehot", 32'(req_done), 32'(1 << mon_e.idx));
                    check("done_error", 32'(req_error), mon_e.err ? 32'(1 << mon_e.idx) : 0);
                    check("done_rdata", 32'(rdata), 32'(mon_e.rdata));
                    check("done_grant_clear", 32'(req_grant), 0);
                    check("frozen_rw", 32'(master_rw), 32'(mon_e.rw));
                    check("frozen_wdata", 32'(master_data_in), 32'(mon_e.wdata));
                    if (!mon_e.err) begin
                        check("hold_streak", 32'(streak), 3);
                        check("done_mrst", 32'(master_rst), 1);
                    end
                end
            end else if (req_error != '0) begin
                check("error_alone", 32'(req_error), 0);
            end
            streak     = (master_state == 3'd5 && !master_rst) ? streak + 1 : 0;
            prev_grant = req_grant;
        end
    end

    task automatic wait_done(input int idx);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (req_done[idx]) begin
                seen           = 1'b1;
                req_valid[idx] = 1'b0;
            end
        end
        if (!seen) check("done_wait_timeout", 0, 1);
    endtask

    task automatic wait_run();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && !master_rst) && n < 50);
        if (n >= 50) check("run_wait_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(req_grant), 0);
        check("rst_done", 32'(req_done), 0);
        check("rst_error", 32'(req_error), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mrst", 32'(master_rst), 1);
        check("rst_mrw", 32'(master_rw), 0);
        check("rst_mdin", 32'(master_data_in), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Single write, requester 1
        req_rw[1]        = 1'b0;
        req_wdata[15:8]  = 8'h3C;
        exp_q.push_back('{idx: 1, err: 1'b0, rdata: 8'h00, rw: 1'b0, wdata: 8'h3C});
        req_valid[1]     = 1'b1;
        @(negedge clk);
        check("w_grant", 32'(req_grant), 32'h2);
        check("w_launch_mrst1", 32'(master_rst), 1);
        check("w_mdin", 32'(master_data_in), 32'h3C);
        check("w_busy", 32'(busy), 1);
        @(negedge clk);
        check("w_launch_mrst2", 32'(master_rst), 1);
        @(negedge clk);
        check("w_run_mrst", 32'(master_rst), 0);
        req_wdata[15:8] = 8'hFF;   // ignored mid-transaction
        req_rw[1]       = 1'b1;
        wait_done(1);
        @(negedge clk);

        // Single read, requester 0: model returns ~A5 = 5A
        req_rw[0]       = 1'b1;
        req_wdata[7:0]  = 8'hA5;
        exp_q.push_back('{idx: 0, err: 1'b0, rdata: 8'h5A, rw: 1'b1, wdata: 8'hA5});
        req_valid[0]    = 1'b1;
        wait_done(0);
        repeat (3) @(negedge clk);
        check("r_rdata_held", 32'(rdata), 32'h5A);

        // Requester 2 withdraws during RUN
        req_rw[2]         = 1'b1;
        req_wdata[23:16]  = 8'h81;
        exp_q.push_back('{idx: 2, err: 1'b0, rdata: 8'h7E, rw: 1'b1, wdata: 8'h81});
        req_valid[2]      = 1'b1;
        wait_run();
        req_valid[2]      = 1'b0;
        wait_done(2);
        @(negedge clk);

        // Async reset mid-RUN on requester 3
        req_rw[3]        = 1'b0;
        req_wdata[31:24] = 8'h42;
        exp_q.push_back('{idx: 3, err: 1'b0, rdata: 8'h7E, rw: 1'b0, wdata: 8'h42});
        req_valid[3]     = 1'b1;
        wait_run();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("ar_mrst", 32'(master_rst), 1);
        check("ar_grant", 32'(req_grant), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_done", 32'(req_done), 0);
        exp_q.delete();
        req_rw[1]       = 1'b0;
        req_wdata[15:8] = 8'h11;
        req_valid       = 4'b1010;
        repeat (2) @(negedge clk);
        check("ar_hold_mrst", 32'(master_rst), 1);
        check("ar_hold_grant", 32'(req_grant), 0);
        exp_q.push_back('{idx: 1, err: 1'b0, rdata: 8'h00, rw: 1'b0, wdata: 8'h11});
        exp_q.push_back('{idx: 3, err: 1'b0, rdata: 8'h00, rw: 1'b0, wdata: 8'h42});
        rst = 1'b1;
        wait_done(1);
        wait_done(3);
        @(negedge clk);

        // Contention: all four held, pointer starts at 0
        req_rw    = 4'b0101;
        req_wdata = {8'h44, 8'h33, 8'h22, 8'h0F};
        exp_q.push_back('{idx: 0, err: 1'b0, rdata: 8'hF0, rw: 1'b1, wdata: 8'h0F});
        exp_q.push_back('{idx: 1, err: 1'b0, rdata: 8'hF0, rw: 1'b0, wdata: 8'h22});
        exp_q.push_back('{idx: 2, err: 1'b0, rdata: 8'hCC, rw: 1'b1, wdata: 8'h33});
        exp_q.push_back('{idx: 3, err: 1'b0, rdata: 8'hCC, rw: 1'b0, wdata: 8'h44});
        exp_q.push_back('{idx: 0, err: 1'b0, rdata: 8'hF0, rw: 1'b1, wdata: 8'h0F});
        req_valid = 4'b1111;
        begin
            int nd = 0;
            int cyc = 0;
            while (nd < 5 && cyc < 500) begin
                @(negedge clk);
                cyc++;
                if (req_done != '0) nd++;
                if (nd == 5) req_valid = '0;
            end
            check("cont_done_count", 32'(nd), 5);
        end
        repeat (3) @(negedge clk);
        check("cont_no_extra", 32'(busy), 0);
        check("cont_queue_empty", 32'(exp_q.size()), 0);

`ifdef I2C_ARB_TIMEOUT_EN
        // Stuck master: requester 1 times out, requester 2 follows
        stuck = 1'b1;
        exp_q.push_back('{idx: 1, err: 1'b1, rdata: 8'hF0, rw: 1'b0, wdata: 8'h22});
        exp_q.push_back('{idx: 2, err: 1'b0, rdata: 8'hCC, rw: 1'b1, wdata: 8'h33});
        req_valid = 4'b0110;
        wait_run();
        begin
            int runc = 1;
            while (req_done == '0 && runc < 100) begin
                @(negedge clk);
                runc++;
            end
            check("to_run_cycles", 32'(runc), TO);
            check("to_error", 32'(req_error), 32'h2);
        end
        stuck        = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("to_mrst_after", 32'(master_rst), 1);
        check("to_next_grant", 32'(req_grant), 32'h4);
        wait_done(2);
        repeat (2) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Transaction-level controller that shares one i2c `master` instance between NUM_REQ requesters. It arbitrates pending requests round-robin and sequences the master through one byte transaction per grant. Sequencing uses the master's active-high `rst` input and its 3-bit `state` output. On completion it returns read data or completion status to the granted requester. It sits directly above `master`, between it and the system-side clients.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LAUNCH_CYCLES, 2, cycles master_rst is held high before each transaction
DONE_HOLD, 2, cycles master is left in DONE so the stop condition completes
TIMEOUT_CYCLES, 1024, RUN-phase watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock, shared with the master
rst  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request; held until that requester's req_done
req_rw  in  NUM_REQ  per-requester direction, 1 = read, 0 = write
req_wdata  in  8*NUM_REQ  per-requester write byte; requester i uses bits [8i+7:8i]
req_grant  out  NUM_REQ  one-hot grant, held for the whole transaction
req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
req_error  out  NUM_REQ  one-cycle pulse coincident with req_done on timeout
rdata  out  8  read byte, valid in the req_done cycle, held until the next completion
busy  out  1  high whenever FSM is not IDLE
master_rst  out  1  drives master.rst (active-high)
master_rw  out  1  drives master.rw
master_data_in  out  8  drives master.data_in
master_state  in  3  from master.state
master_data_out  in  8  from master.data_out

Behaviour:
- Reset (rst low, async): FSM=IDLE; rr pointer=0.
  - req_grant=0, req_done=0, req_error=0, rdata=8'h00, busy=0.
  - master_rst=1, master_rw=0, master_data_in=8'h00.
  - While in reset the master is held idle. Reset mid-transaction aborts it silently: no done pulse.
- FSM states:
  - IDLE
    - master_rst=1.
    - If any req_valid is set, pick winner = first set bit searching upward from pointer, with wrap.
    - Register req_grant (one-hot); latch winner's rw/wdata into master_rw/master_data_in; go to LAUNCH.
    - Latency: req_valid seen at edge N gives grant visible after edge N+1.
  - LAUNCH
    - Hold master_rst=1 for LAUNCH_CYCLES cycles, then drive master_rst=0 and go to RUN.
  - RUN
    - master_rst=0.
    - When master_state==DONE (3'd5) is sampled, capture master_data_out into rdata (reads only; writes leave rdata unchanged) and go to HOLD.
  - HOLD
    - Keep master_rst=0 for DONE_HOLD cycles; then pulse req_done[winner] for 1 cycle.
    - Assert master_rst=1; clear req_grant in the same cycle.
    - Set pointer = winner+1 mod NUM_REQ; return to IDLE.
- Minimum IDLE dwell between transactions is 1 cycle; back-to-back requests are never granted without it.
- master_rw and master_data_in stay frozen from grant until return to IDLE. Requester input changes mid-transaction are ignored.
- req_valid dropped mid-transaction: the transaction completes normally and req_done still pulses.
- Simultaneous requests: pointer order. Every requester is served within NUM_REQ grants (no starvation).
- A requester that re-asserts immediately after done goes behind the others.
- The 3-bit master_state encodings 6 and 7 are treated as "not done".

Optional Feature:
Macro I2C_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to RUN and increments each RUN cycle. When it reaches TIMEOUT_CYCLES before DONE:
  - req_done and req_error pulse together; rdata is unchanged.
  - master_rst=1 the following cycle; FSM goes to IDLE; pointer advances as normal.
- Undefined: no counter; req_error tied to 0; RUN waits indefinitely.

Decomposition:
- Package i2c_pkg: master state encodings (IDLE=0, ADDRESSING=1, WAITING=2, READING=3, WRITING=4, DONE=5), READ=1/WRITE=0 encodings, arbiter FSM state enum.
- One sub-module, i2c_rr_pick: combinational round-robin picker (req vector, pointer) -> one-hot grant plus winner index. The FSM, pointer register and latches stay in i2c_txn_arbiter.

Test Plan:
- Single write: req_valid[1]=1, rw=0, wdata=8'h3C.
  - Expect req_grant=4'b0010 one cycle later, then master_rst high for 2 cycles, then low.
  - Expect master_data_in=8'h3C until DONE+2, then req_done[1] for 1 cycle and req_error=0.
- Single read: model master returns data_out=8'h5A at DONE.
  - Expect rdata=8'h5A in the req_done[0] cycle, held afterwards.
- Contention: req_valid=4'b1111 held continuously.
  - Expect grant order 0,1,2,3,0 with exactly one req_done per grant.
- Requester withdraws: drop req_valid[2] mid-RUN.
  - Expect the transaction still completes and req_done[2] pulses.
- Async reset: pull rst low during RUN.
  - Expect immediate master_rst=1, grant=0, busy=0, no done.
  - After release, pending requests are served from pointer 0.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: master stuck in WAITING.
  - Expect req_done and req_error on the 16th RUN cycle, then master_rst=1 and the next requester granted.
